// File: rtl/pet_cmd_arbiter.sv
// Two-requester command arbiter for the pet stats block: grants A (UART) or B (buttons),
// filters bytes against the sleep flag, then drives hold/gap windows. Optional macro: PET_CMD_ARB_FIXED_PRIO_EN.
module pet_cmd_arbiter #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_valid,
   input  logic [7:0] a_cmd,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_cmd,
   output logic       b_ready,
   input  logic       is_sleeping,
   output logic [7:0] cmd_out,
   output logic       busy,
   output logic       grant_src,
   output logic       reject,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

   localparam logic [7:0] CMD_EAT   = 8'h65;
   localparam logic [7:0] CMD_PLAY  = 8'h70;
   localparam logic [7:0] CMD_BATH  = 8'h62;
   localparam logic [7:0] CMD_SLEEP = 8'h73;
   localparam logic [7:0] CMD_WAKE  = 8'h77;

   state_t      state;
   logic [15:0] cnt;
   logic        last_grant;

   logic        idle;
   logic        pick_b;
   logic        hs_a;
   logic        hs_b;
   logic        hs;
   logic        hs_src;
   logic [7:0]  hs_cmd;
   logic        legal;

   assign idle = (state == IDLE);

   // pick_b only matters on a tie; a lone requester always gets ready
`ifdef PET_CMD_ARB_FIXED_PRIO_EN
   assign pick_b = 1'b1;
`else
   assign pick_b = ~last_grant;
`endif

   assign a_ready = idle & a_valid & (~b_valid | ~pick_b);
   assign b_ready = idle & b_valid & (~a_valid | pick_b);

   assign hs_a   = a_valid & a_ready;
   assign hs_b   = b_valid & b_ready;
   assign hs     = hs_a | hs_b;
   assign hs_src = hs_b;
   assign hs_cmd = hs_b ? b_cmd : a_cmd;

   always_comb begin
      legal = 1'b0;
      if (is_sleeping) begin
         legal = (hs_cmd == CMD_WAKE);
      end else begin
         case (hs_cmd)
            CMD_EAT, CMD_PLAY, CMD_BATH, CMD_SLEEP, CMD_WAKE: legal = 1'b1;
            default:                                          legal = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cmd_out    <= '0;
         busy       <= 1'b0;
         grant_src  <= 1'b0;
         last_grant <= 1'b1;
         reject     <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         reject <= 1'b0;
         case (state)
            IDLE: begin
               if (hs) begin
                  last_grant <= hs_src;
                  if (legal) begin
                     cmd_out   <= hs_cmd;
                     grant_src <= hs_src;
                     cnt       <= HOLD_LOAD;
                     busy      <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     // illegal bytes are consumed so the requester is never stuck
                     reject <= 1'b1;
                     if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  end
               end
            end
            HOLD: begin
               if (cnt == 16'd0) begin
                  cmd_out <= 8'h00;
                  cnt     <= GAP_LOAD;
                  state   <= GAP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            GAP: begin
               if (cnt == 16'd0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               cmd_out <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pet_cmd_arbiter.sv
// Randomized scoreboard bench for pet_cmd_arbiter: a time-based reference model predicts
// readys and pushes expected commands/rejects; a monitor pops them as the DUT presents them.
module tb_pet_cmd_arbiter;
   localparam int HOLD = 4;
   localparam int GAP  = 4;
`ifdef PET_CMD_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      int         start;
      logic [7:0] cmd;
      bit         src;
      bit         rej;
   } exp_t;

   typedef struct {
      int   cyc;
      logic src;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_valid = 1'b0;
   logic [7:0] a_cmd = 8'h00;
   logic       a_ready;
   logic       b_valid = 1'b0;
   logic [7:0] b_cmd = 8'h00;
   logic       b_ready;
   logic       is_sleeping = 1'b0;
   logic [7:0] cmd_out;
   logic       busy;
   logic       grant_src;
   logic       reject;
   logic [7:0] drop_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   exp_t       sb[$];
   obs_t       obs[$];
   logic [7:0] a_q[$];
   logic [7:0] b_q[$];

   // reference model state: first cycle the arbiter may grant again, and the last granted source
   int m_free_at = 0;
   bit m_last = 1'b1;
   bit a_hs = 1'b0;
   bit b_hs = 1'b0;

   int a_rate = 100;
   int b_rate = 100;
   bit drop_en = 1'b0;
   int sleep_mode = 0;
   bit sleep_val = 1'b0;

   int   mon_cmd = 0;
   int   mon_busy = 0;
   int   mon_rej = 0;
   int   mon_drops = 0;
   bit   mon_gsrc = 1'b0;
   bit   active = 1'b0;
   exp_t cur;

   pet_cmd_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
      .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
      .is_sleeping(is_sleeping),
      .cmd_out(cmd_out), .busy(busy), .grant_src(grant_src),
      .reject(reject), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, got, want, cyc);
      end
   endfunction

   function automatic bit legal_cmd(logic [7:0] c, bit slp);
      if (slp) return c == 8'h77;
      return c inside {8'h65, 8'h70, 8'h62, 8'h73, 8'h77};
   endfunction

   // requesters keep valid+data until consumed; optionally withdraw without a handshake
   task automatic drive();
      if (a_hs || !a_valid) begin
         a_valid = (a_q.size() > 0) && ($urandom_range(99) < a_rate);
         a_cmd   = a_valid ? a_q[0] : 8'($urandom);
      end else if (drop_en && $urandom_range(15) == 0) begin
         a_valid = 1'b0;
      end
      if (b_hs || !b_valid) begin
         b_valid = (b_q.size() > 0) && ($urandom_range(99) < b_rate);
         b_cmd   = b_valid ? b_q[0] : 8'($urandom);
      end else if (drop_en && $urandom_range(15) == 0) begin
         b_valid = 1'b0;
      end
      a_hs = 1'b0;
      b_hs = 1'b0;
      case (sleep_mode)
         0:       is_sleeping = sleep_val;
         1:       is_sleeping = ($urandom_range(3) == 0);
         default: is_sleeping = ~is_sleeping;
      endcase
   endtask

   task automatic step();
      bit         idle, pick_b, ea, eb, src, ok;
      logic [7:0] c;
      @(negedge clk);
      idle   = (cyc >= m_free_at);
      pick_b = FIXED ? 1'b1 : !m_last;
      ea = idle && a_valid && (!b_valid || !pick_b);
      eb = idle && b_valid && (!a_valid || pick_b);
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      a_hs = a_valid && ea;
      b_hs = b_valid && eb;
      if (a_hs || b_hs) begin
         src = b_hs;
         c   = b_hs ? b_cmd : a_cmd;
         if (b_hs) void'(b_q.pop_front());
         else      void'(a_q.pop_front());
         ok = legal_cmd(c, is_sleeping);
         sb.push_back('{start: cyc + 1, cmd: c, src: src, rej: !ok});
         m_last = src;
         if (ok) m_free_at = cyc + 1 + HOLD + GAP;
      end
      @(posedge clk); #1;
      drive();
   endtask

   task automatic do_reset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("rst_cmd_out", cmd_out, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_src", grant_src, 1'b0);
      chk("rst_reject", reject, 1'b0);
      chk("rst_drop_cnt", drop_cnt, 8'h00);
      a_hs = 1'b0;
      b_hs = 1'b0;
      a_q.delete();
      b_q.delete();
      sb.delete();
      obs.delete();
      mon_cmd  = 0;
      mon_busy = 0;
      mon_rej  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      m_free_at = cyc;
      m_last    = 1'b1;
   endtask

   // monitor: pops the scoreboard whenever the DUT starts a command or pulses reject
   initial begin
      exp_t e;
      int   off;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active    = 1'b0;
            mon_drops = 0;
            mon_gsrc  = 1'b0;
            continue;
         end
         if (reject) begin
            mon_rej++;
            if (sb.size() == 0) begin
               chk("reject_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("reject_kind", 1, e.rej);
               chk("reject_cycle", cyc, e.start);
               if (mon_drops < 255) mon_drops++;
            end
         end
         if (cmd_out != 8'h00 && !active) begin
            if (sb.size() == 0) begin
               chk("cmd_unexpected", cmd_out, 8'h00);
            end else begin
               e = sb.pop_front();
               chk("cmd_kind", 0, e.rej);
               chk("cmd_cycle", cyc, e.start);
               chk("cmd_byte", cmd_out, e.cmd);
               cur      = e;
               active   = 1'b1;
               mon_gsrc = e.src;
               obs.push_back('{cyc: cyc, src: grant_src});
            end
         end
         if (active) begin
            off = cyc - cur.start;
            chk("cmd_window", cmd_out, (off < HOLD) ? cur.cmd : 8'h00);
            chk("busy_active", busy, 1'b1);
            if (off >= HOLD + GAP - 1) active = 1'b0;
         end else begin
            chk("busy_idle", busy, 1'b0);
         end
         chk("grant_src", grant_src, mon_gsrc);
         chk("drop_cnt", drop_cnt, mon_drops);
         if (cmd_out != 8'h00) mon_cmd++;
         if (busy) mon_busy++;
      end
   end

   initial begin
      logic [7:0] pool[10] = '{8'h65, 8'h70, 8'h62, 8'h73, 8'h77, 8'h77, 8'h41, 8'h00, 8'hFF, 8'h65};
      bit         want_src[4];

      // single request from A
      do_reset();
      a_q.push_back(8'h65);
      drive();
      repeat (12) step();
      chk("p1_cmd_cycles", mon_cmd, 4);
      chk("p1_busy_cycles", mon_busy, 8);
      chk("p1_obs_count", obs.size(), 1);
      if (obs.size() > 0) chk("p1_grant_src", obs[0].src, 1'b0);

      // both held: arbitration order and spacing
      do_reset();
      repeat (3) a_q.push_back(8'h70);
      repeat (3) b_q.push_back(8'h62);
      drive();
      repeat (60) step();
      if (FIXED) want_src = '{1'b1, 1'b1, 1'b1, 1'b0};
      else       want_src = '{1'b0, 1'b1, 1'b0, 1'b1};
      chk("p2_obs_count", obs.size(), 6);
      if (obs.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("p2_order", obs[i].src, want_src[i]);
            if (i > 0) chk("p2_spacing", obs[i].cyc - obs[i-1].cyc, HOLD + GAP + 1);
         end
      end

      // asleep: non-wake byte dropped, wake accepted
      do_reset();
      sleep_val = 1'b1;
      b_q.push_back(8'h65);
      b_q.push_back(8'h77);
      drive();
      repeat (12) step();
      chk("p3_drop_cnt", drop_cnt, 8'd1);
      chk("p3_rejects", mon_rej, 1);
      chk("p3_cmd_cycles", mon_cmd, 4);
      chk("p3_grant_src", grant_src, 1'b1);

      // drop counter saturation
      do_reset();
      sleep_val = 1'b0;
      repeat (260) a_q.push_back(8'h41);
      drive();
      repeat (265) step();
      chk("p4_drop_sat", drop_cnt, 8'd255);
      chk("p4_cmd_cycles", mon_cmd, 0);
      chk("p4_rejects", mon_rej, 260);

      // reset in the second HOLD cycle
      do_reset();
      a_q.push_back(8'h73);
      drive();
      repeat (2) step();
      chk("p5_pre_cmd", cmd_out, 8'h73);
      chk("p5_pre_busy", busy, 1'b1);
      do_reset();
      b_q.push_back(8'h62);
      drive();
      repeat (11) step();
      chk("p5_post_cmd_cycles", mon_cmd, 4);

      // sleep flag toggling mid-sequence
      do_reset();
      a_q.push_back(8'h70);
      drive();
      step();
      sleep_mode = 2;
      repeat (11) step();
      chk("p6_cmd_cycles", mon_cmd, 4);
      chk("p6_busy_cycles", mon_busy, 8);

      // randomized traffic
      sleep_mode = 0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         a_q.push_back(pool[$urandom_range(9)]);
         b_q.push_back(pool[$urandom_range(9)]);
      end
      sleep_mode = 1;
      drop_en = 1'b1;
      a_rate = 60;
      b_rate = 60;
      drive();
      repeat (1500) step();
      drop_en = 1'b0;
      a_rate = 100;
      b_rate = 100;
      repeat (800) step();
      repeat (20) step();
      chk("sb_drain", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pet_cmd_arbiter.md
# pet_cmd_arbiter

Command arbiter and sequencer sitting in front of the pet statistics block. Two requesters share the single 8-bit command input of the stats block: the UART receive path (A) and the push-button encoder (B). The arbiter grants one requester at a time and filters commands against the sleep state. It drives each accepted command byte for a fixed hold window, then forces 0x00 for a gap window. The gap re-arms the stats block's one-command-per-release latch.

## Interface
- HOLD_CYCLES, default 4: cycles a command byte is driven on cmd_out; legal range 1..65535
- GAP_CYCLES, default 4: cycles 0x00 is driven after each command; legal range 1..65535
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A (UART) has a command
- a_cmd  in  8  requester A command byte (ASCII)
- a_ready  out  1  requester A handshake accept
- b_valid  in  1  requester B (buttons) has a command
- b_cmd  in  8  requester B command byte (ASCII)
- b_ready  out  1  requester B handshake accept
- is_sleeping  in  1  sleep flag fed back from the stats block
- cmd_out  out  8  command byte to the stats block; 0x00 = no command
- busy  out  1  high in HOLD or GAP
- grant_src  out  1  source of the last accepted command (0 = A, 1 = B)
- reject  out  1  one-cycle pulse when an accepted byte is discarded
- drop_cnt  out  8  saturating count of discarded bytes

## Operation
- Reset values:
  - cmd_out = 0x00, busy = 0, grant_src = 0, reject = 0, drop_cnt = 0.
  - Internal last_grant = 1, so A wins the first tie.
  - State = IDLE.
- Legal command set:
  - Awake: 0x65 'e', 0x70 'p', 0x62 'b', 0x73 's', 0x77 'w'.
  - Asleep: only 0x77 'w' is legal.
  - Legality is judged on is_sleeping in the handshake cycle.
- State IDLE:
  - a_ready/b_ready are combinational.
  - Only one ready is high in any cycle.
  - If only one valid is high, that requester gets ready.
  - If both valids are high, the requester not equal to last_grant gets ready (round-robin).
  - A handshake is valid && ready in the same cycle.
- On a handshake of a legal byte:
  - Register the byte into cmd_out.
  - Set grant_src and last_grant to the granted source.
  - Go to HOLD and load the counter with HOLD_CYCLES-1.
- On a handshake of an illegal byte:
  - The byte is consumed, and reject pulses high for the next cycle.
  - drop_cnt increments, saturating at 255.
  - last_grant updates; state stays IDLE; cmd_out stays 0x00.
- State HOLD:
  - cmd_out holds the byte and both readys are 0.
  - The counter decrements each cycle.
  - When the counter is 0: cmd_out <= 0x00, load GAP_CYCLES-1, go to GAP.
- State GAP:
  - cmd_out = 0x00 and both readys are 0.
  - When the counter is 0: go to IDLE.
- Changes of is_sleeping during HOLD or GAP do not affect the sequence in flight.
- Requesters hold valid and data stable until ready. Valid dropping without a handshake is legal, and nothing is consumed.

## Timing
- Handshake in cycle k (legal byte):
  - cmd_out = byte in cycles k+1 .. k+HOLD_CYCLES.
  - cmd_out = 0x00 in cycles k+HOLD_CYCLES+1 .. k+HOLD_CYCLES+GAP_CYCLES.
  - Earliest next handshake is cycle k+HOLD_CYCLES+GAP_CYCLES+1.
- Peak throughput: one command per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Illegal byte: reject high in cycle k+1. A new handshake is allowed in cycle k+1.
- busy is high exactly while state is HOLD or GAP.
- rst_n low at any point, including mid-HOLD:
  - All outputs return to reset values immediately (asynchronously).
  - The in-flight command is abandoned.
  - The first edge after release is in IDLE.
- Counters are 16 bits. drop_cnt never wraps.

## Configuration
- PET_CMD_ARB_FIXED_PRIO_EN defined:
  - On a tie, B (buttons) always wins.
  - last_grant is still tracked for grant_src, but does not influence arbitration.
- Not defined: round-robin as described under Operation.

## Test plan
- Reset, then a_valid=1, a_cmd=0x65 for one request (HOLD=4, GAP=4):
  - a_ready high in the first IDLE cycle.
  - cmd_out=0x65 for exactly 4 cycles, then 0x00 for 4 cycles.
  - busy high for 8 cycles; grant_src=0.
- a_valid and b_valid held high with 0x70/0x62:
  - Grant order A, B, A, B.
  - Successive handshakes spaced 9 cycles apart.
  - With PET_CMD_ARB_FIXED_PRIO_EN defined, the order is B, B, B.
- is_sleeping=1, b_cmd=0x65:
  - b_ready handshake, reject pulse 1 cycle, drop_cnt=1, cmd_out stays 0x00.
  - Then b_cmd=0x77 is accepted and driven for 4 cycles.
- 260 illegal bytes (0x41) from A: drop_cnt saturates at 255 and cmd_out never leaves 0x00.
- rst_n asserted in the 2nd HOLD cycle of 0x73: cmd_out=0x00 and busy=0 immediately, and IDLE after release.
- is_sleeping toggles mid-HOLD of 0x70: full 4-cycle HOLD plus 4-cycle GAP complete unchanged.
